irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Maskable interrupt arbiter for the ForthCPU. It collects up to NSRC peripheral interrupt sources, latches them, and applies per-source masks and fixed priority. It drives the single maskable INT1 request into the interrupt state machine and tracks the in-service source until end-of-interrupt. The CPU reads the winning source index (CAUSE) through a small register port.

## Interface
- NSRC, default 8, number of sources (2..16)
- CLK  in  1  clock
- RESET  in  1  reset, asynchronous, active-high
- COMMIT  in  1  CPU commit strobe; ACK and EOI are honoured only when it is high
- SRC  in  NSRC  peripheral requests, synchronous to CLK
- ACK  in  1  INT1 vector taken (the PC_LD_INT1 registered output of the interrupt state machine)
- EOI  in  1  end of INT1 service (RETI decoded while servicing INT1)
- WR  in  1  register write strobe
- ADDR  in  2  register select
- DIN  in  16  write data
- DOUT  out  16  read data, combinational from ADDR
- INT1  out  1  registered maskable request to the interrupt state machine

## Operation
- Registers, selected by ADDR:
  - 0 PENDING: read; write 1 clears edge-mode bits.
  - 1 MASK: read/write; 1 = enabled.
  - 2 CAUSE: read; bit15 = BUSY, bits3:0 = in-service index.
  - 3 EDGE: read/write; 1 = edge mode. Present only when the macro in Configuration is defined.
- Unused high bits read 0. Writes to read-only registers are ignored.
- Pending capture runs every CLK and is not gated by COMMIT, so single-cycle pulses are never lost.
  - Level-mode bit: PENDING[i] <= SRC[i]. Not clearable by write.
  - Edge-mode bit: set on SRC[i] rising (SRC & ~SRC_q). Cleared by W1C or by ACK of that source.
- Winner: the lowest index i with PENDING[i] & MASK[i]. Index 0 has highest priority.
- FSM state IDLE (BUSY=0):
  - INT1 <= any enabled pending.
  - On COMMIT & ACK: latch winner into CAUSE, set BUSY, clear the winner's edge pending bit, INT1 <= 0 → SERVICE.
- FSM state SERVICE (BUSY=1):
  - INT1 held 0. No nesting within the INT1 level.
  - On COMMIT & EOI: BUSY <= 0 → IDLE. CAUSE keeps its last index.
- ACK while IDLE with no enabled pending: ignored, BUSY stays 0.
- ACK while SERVICE: ignored.
- EOI while IDLE: ignored.
- Reset values: PENDING=0, MASK=0 (all masked), EDGE=0, SRC_q=0, CAUSE=0, BUSY=0, INT1=0, state IDLE.
- RESET mid-service returns to IDLE immediately and discards all pending.

## Timing
- SRC rise at edge n → PENDING set at n+1 → INT1 high at n+2.
- ACK (with COMMIT) at edge n → CAUSE and BUSY valid and INT1 low at n+1.
- EOI at edge n → BUSY low at n+1. If a source is still enabled and pending, INT1 is high at n+2.
- W1C clear and a new rising edge on the same bit in the same cycle: set wins.
- Edge-pending clear by ACK and a new rising edge on the same bit in the same cycle: set wins, and the request re-fires after EOI.
- MASK write at edge n affects INT1 at n+1. Masking a source after ACK does not affect BUSY or CAUSE.
- DOUT is combinational and reflects register state after the previous edge.

## Configuration
- IRQARB_EDGE_EN defined: the EDGE register exists and each source is individually level or edge.
- IRQARB_EDGE_EN undefined:
  - All sources are level-mode and SRC_q is removed.
  - ADDR 3 reads 0 and writes to it are ignored.
  - PENDING W1C has no effect.

## Structure
- Register addresses (IRQ_REG_PENDING/MASK/CAUSE/EDGE) and FSM state codes (IRQ_STATE_IDLE/SERVICE) go in constants.v next to the INT_STATE_* codes.
- Sub-module irq_prio_enc: combinational lowest-index-first priority encoder, NSRC in, outputs valid + 4-bit index.

## Test plan
- Level SRC[3]=1, MASK=0x08 → INT1 high 2 cycles later. ACK → CAUSE=0x8003, INT1=0. EOI with SRC[3] still high → INT1 high again.
- SRC[5] and SRC[2] rise together, MASK=0xFF → ACK gives CAUSE index 2. After EOI, a second ACK gives index 5.
- Edge mode, SRC[1] one-cycle pulse, MASK=0 → PENDING=0x02 and INT1 stays 0. Write MASK=0x02 → INT1 high next cycle.
- Edge SRC[4] pending, then W1C PENDING=0x10 in the same cycle as a new SRC[4] rise → PENDING[4] stays 1.
- Assert RESET during SERVICE with PENDING=0xFF → all registers 0, INT1=0. Next rising SRC[0] is captured normally.
- ACK with COMMIT=0, and EOI while IDLE → no state change, CAUSE unchanged.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter_pkg: register map, FSM state codes and CAUSE word layout for the INT1 arbiter.
package irq_arbiter_pkg;
  localparam logic [1:0] IRQ_REG_PENDING = 2'd0;
  localparam logic [1:0] IRQ_REG_MASK = 2'd1;
  localparam logic [1:0] IRQ_REG_CAUSE = 2'd2;
  localparam logic [1:0] IRQ_REG_EDGE = 2'd3;
  localparam logic [0:0] IRQ_STATE_IDLE = 1'b0;
  localparam logic [0:0] IRQ_STATE_SERVICE = 1'b1;
  typedef struct packed {
    logic busy;
    logic [10:0] rsvd;
    logic [3:0] idx;
  } irq_cause_t;
  function automatic irq_cause_t cause_word(input logic busy, input logic [3:0] idx);
    return '{busy: busy, rsvd: '0, idx: idx};
  endfunction
endpackage

// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: CPU/peripheral side of the INT1 arbiter (commit strobes, sources, register port).
interface irq_arbiter_if #(
  parameter int NSRC = 8
);
  logic COMMIT;
  logic [NSRC-1:0] SRC;
  logic ACK;
  logic EOI;
  logic WR;
  logic [1:0] ADDR;
  logic [15:0] DIN;
  logic [15:0] DOUT;
  logic INT1;
  modport master(output COMMIT, SRC, ACK, EOI, WR, ADDR, DIN, input DOUT, INT1);
  modport slave(input COMMIT, SRC, ACK, EOI, WR, ADDR, DIN, output DOUT, INT1);
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-first priority encoder; index 0 wins.
module irq_prio_enc #(
  parameter int NSRC = 8
) (
  input logic [NSRC-1:0] i_req,
  output logic o_valid,
  output logic [3:0] o_idx
);
  always_comb begin
    o_valid = |i_req;
    o_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) o_idx = i_req[i] ? 4'(i) : o_idx;
  end
endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: latches sources, applies mask and fixed priority, drives INT1 and tracks the in-service source.
// Define IRQARB_EDGE_EN to add the EDGE register and per-source rising-edge capture.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int NSRC = 8
) (
  input logic CLK,
  input logic RESET,
  irq_arbiter_if.slave bus
);
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] w_pend_nxt;
  logic [NSRC-1:0] w_enabled;
  logic [0:0] r_state;
  logic [3:0] r_cause;
  logic [3:0] w_idx;
  logic r_int1;
  logic w_valid;
  logic w_take;
  logic w_eoi;
  logic w_busy;
  logic [15:0] w_edge_rd;
  assign w_busy = r_state == IRQ_STATE_SERVICE;
  assign w_enabled = r_pend & r_mask;
  irq_prio_enc #(.NSRC(NSRC)) u_enc (
    .i_req(w_enabled),
    .o_valid(w_valid),
    .o_idx(w_idx)
  );
  assign w_take = !w_busy && bus.COMMIT && bus.ACK && w_valid;
  assign w_eoi = w_busy && bus.COMMIT && bus.EOI;
`ifdef IRQARB_EDGE_EN
  logic [NSRC-1:0] r_edge;
  logic [NSRC-1:0] r_src_q;
  logic [NSRC-1:0] w_clr;
  // A fresh rising edge outranks a same-cycle W1C or ACK clear so no request is lost.
  assign w_clr = (bus.WR && bus.ADDR == IRQ_REG_PENDING ? bus.DIN[NSRC-1:0] : '0) |
                 (w_take ? NSRC'(1) << w_idx : '0);
  assign w_pend_nxt = (r_edge & ((r_pend & ~w_clr) | (bus.SRC & ~r_src_q))) | (~r_edge & bus.SRC);
  assign w_edge_rd = 16'(r_edge);
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_edge <= '0;
      r_src_q <= '0;
    end else begin
      r_src_q <= bus.SRC;
      if (bus.WR && bus.ADDR == IRQ_REG_EDGE) r_edge <= bus.DIN[NSRC-1:0];
    end
`else
  assign w_pend_nxt = bus.SRC;
  assign w_edge_rd = '0;
`endif
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_pend <= '0;
      r_mask <= '0;
      r_cause <= '0;
      r_state <= IRQ_STATE_IDLE;
      r_int1 <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (bus.WR && bus.ADDR == IRQ_REG_MASK) r_mask <= bus.DIN[NSRC-1:0];
      if (w_take) r_cause <= w_idx;
      r_state <= w_take ? IRQ_STATE_SERVICE : w_eoi ? IRQ_STATE_IDLE : r_state;
      r_int1 <= !w_busy && !w_take && w_valid;
    end
  always_comb
    bus.DOUT = bus.ADDR == IRQ_REG_PENDING ? 16'(r_pend) :
               bus.ADDR == IRQ_REG_MASK ? 16'(r_mask) :
               bus.ADDR == IRQ_REG_CAUSE ? cause_word(w_busy, r_cause) : w_edge_rd;
  assign bus.INT1 = r_int1;
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed scenarios plus randomized traffic against a rule-level reference model.
module tb_irq_arbiter;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  irq_arbiter_if #(.NSRC(8)) b ();
  irq_arbiter #(.NSRC(8)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(b)
  );
  always #5 CLK = ~CLK;
  logic [7:0] m_pend, m_mask, m_edge, m_srcq;
  logic [3:0] m_cause;
  logic m_busy, m_int1;

  function automatic logic [15:0] mreg(input logic [1:0] a);
    case (a)
      2'd0: return {8'h0, m_pend};
      2'd1: return {8'h0, m_mask};
      2'd2: return {m_busy, 11'h0, m_cause};
      default: begin
`ifdef IRQARB_EDGE_EN
        return {8'h0, m_edge};
`else
        return 16'h0;
`endif
      end
    endcase
  endfunction

  task automatic mreset();
    m_pend = 0; m_mask = 0; m_edge = 0; m_srcq = 0; m_cause = 0; m_busy = 0; m_int1 = 0;
  endtask

  task automatic clr_in();
    b.COMMIT = 0; b.ACK = 0; b.EOI = 0; b.WR = 0; b.ADDR = 0; b.DIN = 0;
  endtask

  // one clock: reference model derived from the source/mask/priority rules, then the edge
  task automatic cyc();
    int win;
    logic [7:0] np, nm, ne, sq;
    logic take, eoi;
    win = -1;
    for (int i = 7; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
    take = !m_busy && b.COMMIT && b.ACK && win >= 0;
    eoi = m_busy && b.COMMIT && b.EOI;
    nm = (b.WR && b.ADDR == 2'd1) ? b.DIN[7:0] : m_mask;
    ne = m_edge;
`ifdef IRQARB_EDGE_EN
    if (b.WR && b.ADDR == 2'd3) ne = b.DIN[7:0];
`endif
    sq = b.SRC;
    for (int i = 0; i < 8; i++)
      if (!m_edge[i]) np[i] = b.SRC[i];
      else np[i] = (b.SRC[i] && !m_srcq[i]) ||
                   (m_pend[i] && !(b.WR && b.ADDR == 2'd0 && b.DIN[i]) && !(take && win == i));
    @(posedge CLK);
    #1;
    m_int1 = !m_busy && !take && win >= 0;
    if (take) begin m_busy = 1; m_cause = 4'(win); end
    else if (eoi) m_busy = 0;
    m_pend = np; m_mask = nm; m_edge = ne; m_srcq = sq;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    b.WR = 1; b.ADDR = a; b.DIN = d;
    cyc();
    b.WR = 0; b.DIN = 0;
  endtask

  task automatic ack();
    b.COMMIT = 1; b.ACK = 1;
    cyc();
    b.COMMIT = 0; b.ACK = 0;
  endtask

  task automatic eoi();
    b.COMMIT = 1; b.EOI = 1;
    cyc();
    b.COMMIT = 0; b.EOI = 0;
  endtask

  task automatic do_reset();
    RESET = 1; clr_in(); b.SRC = 0; mreset();
    repeat (2) @(posedge CLK);
    #1 RESET = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 4; a++) begin
      b.ADDR = 2'(a); #1; n_chk++;
      if (b.DOUT !== 16'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h want %h", a, b.DOUT, 16'h0); end
    end
    n_chk++;
    if (b.INT1 !== 1'b0) begin n_fail++; $display("FAIL reset_int1: got %b want 0", b.INT1); end
  endtask

  task automatic test_level();
    do_reset();
    wr(2'd1, 16'h0008);
    b.SRC = 8'h08;
    cyc();
    b.ADDR = 2'd0; #1; n_chk++;
    if (b.DOUT !== 16'h0008 || b.INT1 !== 1'b0) begin n_fail++; $display("FAIL level_capture: pend %h int1 %b want 0008/0", b.DOUT, b.INT1); end
    cyc();
    n_chk++;
    if (b.INT1 !== 1'b1) begin n_fail++; $display("FAIL level_int1: got %b want 1", b.INT1); end
    ack();
    b.ADDR = 2'd2; #1; n_chk++;
    if (b.DOUT !== 16'h8003 || b.INT1 !== 1'b0) begin n_fail++; $display("FAIL level_ack: cause %h int1 %b want 8003/0", b.DOUT, b.INT1); end
    eoi();
    #1; n_chk++;
    if (b.DOUT !== 16'h0003 || b.INT1 !== 1'b0) begin n_fail++; $display("FAIL level_eoi: cause %h int1 %b want 0003/0", b.DOUT, b.INT1); end
    cyc();
    n_chk++;
    if (b.INT1 !== 1'b1) begin n_fail++; $display("FAIL level_refire: got %b want 1", b.INT1); end
  endtask

  task automatic test_priority();
    do_reset();
    wr(2'd1, 16'h00FF);
    b.SRC = 8'h24;
    cyc(); cyc();
    ack();
    b.ADDR = 2'd2; #1; n_chk++;
    if (b.DOUT !== 16'h8002) begin n_fail++; $display("FAIL prio_first: got %h want %h", b.DOUT, 16'h8002); end
    b.SRC = 8'h20;
    eoi();
    cyc();
    n_chk++;
    if (b.INT1 !== 1'b1) begin n_fail++; $display("FAIL prio_refire: got %b want 1", b.INT1); end
    ack();
    b.ADDR = 2'd2; #1; n_chk++;
    if (b.DOUT !== 16'h8005) begin n_fail++; $display("FAIL prio_second: got %h want %h", b.DOUT, 16'h8005); end
    eoi();
  endtask

`ifdef IRQARB_EDGE_EN
  task automatic test_edge();
    do_reset();
    wr(2'd3, 16'h00FF);
    b.SRC = 8'h02; cyc();
    b.SRC = 8'h00; cyc();
    b.ADDR = 2'd0; #1; n_chk++;
    if (b.DOUT !== 16'h0002 || b.INT1 !== 1'b0) begin n_fail++; $display("FAIL edge_masked: pend %h int1 %b want 0002/0", b.DOUT, b.INT1); end
    wr(2'd1, 16'h0002);
    cyc();
    n_chk++;
    if (b.INT1 !== 1'b1) begin n_fail++; $display("FAIL edge_unmask: got %b want 1", b.INT1); end
    b.SRC = 8'h10; cyc();
    b.SRC = 8'h00; cyc(); cyc();
    b.SRC = 8'h10;
    wr(2'd0, 16'h0010);
    b.ADDR = 2'd0; #1; n_chk++;
    if (b.DOUT !== 16'h0012) begin n_fail++; $display("FAIL edge_w1c_setwins: got %h want %h", b.DOUT, 16'h0012); end
    b.SRC = 8'h00;
    wr(2'd0, 16'h0010);
    b.ADDR = 2'd0; #1; n_chk++;
    if (b.DOUT !== 16'h0002) begin n_fail++; $display("FAIL edge_w1c: got %h want %h", b.DOUT, 16'h0002); end
    b.SRC = 8'h02;
    ack();
    b.SRC = 8'h00;
    b.ADDR = 2'd0; #1; n_chk++;
    if (b.DOUT !== 16'h0002) begin n_fail++; $display("FAIL edge_ack_setwins: got %h want %h", b.DOUT, 16'h0002); end
    eoi(); cyc();
    n_chk++;
    if (b.INT1 !== 1'b1) begin n_fail++; $display("FAIL edge_ack_refire: got %b want 1", b.INT1); end
    ack();
    b.ADDR = 2'd0; #1; n_chk++;
    if (b.DOUT !== 16'h0000) begin n_fail++; $display("FAIL edge_ack_clear: got %h want %h", b.DOUT, 16'h0000); end
    eoi();
  endtask
`else
  task automatic test_no_edge();
    do_reset();
    wr(2'd3, 16'h00FF);
    b.ADDR = 2'd3; #1; n_chk++;
    if (b.DOUT !== 16'h0000) begin n_fail++; $display("FAIL noedge_reg3: got %h want %h", b.DOUT, 16'h0000); end
    b.SRC = 8'h01; cyc();
    wr(2'd0, 16'h0001);
    b.ADDR = 2'd0; #1; n_chk++;
    if (b.DOUT !== 16'h0001) begin n_fail++; $display("FAIL noedge_w1c: got %h want %h", b.DOUT, 16'h0001); end
    b.SRC = 8'h00; cyc();
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    wr(2'd1, 16'h00FF);
    b.SRC = 8'hFF;
    cyc(); cyc();
    ack();
    b.ADDR = 2'd2; #1; n_chk++;
    if (b.DOUT !== 16'h8000) begin n_fail++; $display("FAIL rstmid_busy: got %h want %h", b.DOUT, 16'h8000); end
    #1 RESET = 1; mreset();
    for (int a = 0; a < 4; a++) begin
      b.ADDR = 2'(a); #1; n_chk++;
      if (b.DOUT !== 16'h0 || b.INT1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_reg%0d: got %h int1 %b want 0000/0", a, b.DOUT, b.INT1); end
    end
    b.SRC = 8'h00;
    @(posedge CLK); #1 RESET = 0;
    b.SRC = 8'h01; cyc();
    b.ADDR = 2'd0; #1; n_chk++;
    if (b.DOUT !== 16'h0001) begin n_fail++; $display("FAIL rstmid_capture: got %h want %h", b.DOUT, 16'h0001); end
  endtask

  task automatic test_ignored();
    do_reset();
    wr(2'd1, 16'h00FF);
    b.SRC = 8'h00; cyc();
    ack();
    b.ADDR = 2'd2; #1; n_chk++;
    if (b.DOUT !== 16'h0000) begin n_fail++; $display("FAIL ign_ack_empty: got %h want %h", b.DOUT, 16'h0000); end
    b.SRC = 8'h08; cyc(); cyc();
    b.ACK = 1; cyc(); b.ACK = 0;
    b.ADDR = 2'd2; #1; n_chk++;
    if (b.DOUT !== 16'h0000 || b.INT1 !== 1'b1) begin n_fail++; $display("FAIL ign_ack_nocommit: cause %h int1 %b want 0000/1", b.DOUT, b.INT1); end
    eoi();
    #1; n_chk++;
    if (b.DOUT !== 16'h0000 || b.INT1 !== 1'b1) begin n_fail++; $display("FAIL ign_eoi_idle: cause %h int1 %b want 0000/1", b.DOUT, b.INT1); end
    ack();
    b.ADDR = 2'd2; #1;
    b.COMMIT = 1; b.ACK = 1; b.SRC = 8'h01; cyc(); clr_in();
    b.ADDR = 2'd2; #1; n_chk++;
    if (b.DOUT !== 16'h8003) begin n_fail++; $display("FAIL ign_ack_service: got %h want %h", b.DOUT, 16'h8003); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) b.SRC = 8'($urandom);
      b.COMMIT = $urandom_range(0, 3) != 0;
      b.ACK = $urandom_range(0, 2) == 0;
      b.EOI = $urandom_range(0, 2) == 0;
      b.WR = $urandom_range(0, 4) == 0;
      b.ADDR = 2'($urandom);
      b.DIN = 16'($urandom);
      cyc();
      clr_in();
      n_chk++;
      if (b.INT1 !== m_int1) begin n_fail++; $display("FAIL rand_int1 @%0d: got %b want %b", n, b.INT1, m_int1); end
      for (int a = 0; a < 4; a++) begin
        b.ADDR = 2'(a); #1; n_chk++;
        if (b.DOUT !== mreg(2'(a))) begin n_fail++; $display("FAIL rand_reg%0d @%0d: got %h want %h", a, n, b.DOUT, mreg(2'(a))); end
      end
    end
  endtask

  initial begin
    clr_in();
    b.SRC = 0;
    mreset();
    test_reset();
    test_level();
    test_priority();
`ifdef IRQARB_EDGE_EN
    test_edge();
`else
    test_no_edge();
`endif
    test_reset_mid();
    test_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
